// File: rtl/pipe_rxdetect_seq.sv
// Receiver-detect sequencer: settles the PHY, pulses the shared TxDetectRx,
// gathers per-lane PhyStatus/RxStatus and retries on timeout.
module pipe_rxdetect_seq #(
  parameter int NUM_LANES      = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_RETRIES    = 2
) (
  input  logic                   pclk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NUM_LANES-1:0]   phy_status,
  input  logic [3*NUM_LANES-1:0] rx_status,
  output logic                   tx_detectrx,
  output logic                   tx_elecidle,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_LANES-1:0]   detected_lanes,
  output logic                   timeout_err
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRIES);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DETECT
  } state_t;

  state_t               state;
  logic [SW-1:0]        settle_cnt;
  logic [TW-1:0]        timeout_cnt;
  logic [RW-1:0]        retry_cnt;
  logic [NUM_LANES-1:0] seen;
  logic [NUM_LANES-1:0] result;

  logic [NUM_LANES-1:0] rx_ok;
  logic [NUM_LANES-1:0] seen_n;
  logic [NUM_LANES-1:0] result_n;

  // Only the first PhyStatus of a lane in an attempt is taken.
  always_comb begin
    rx_ok = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      rx_ok[i] = (rx_status[3*i +: 3] == 3'b011);
    end
    seen_n   = seen | phy_status;
    result_n = result | (phy_status & ~seen & rx_ok);
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      settle_cnt     <= '0;
      timeout_cnt    <= '0;
      retry_cnt      <= '0;
      seen           <= '0;
      result         <= '0;
      tx_detectrx    <= 1'b0;
      tx_elecidle    <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      detected_lanes <= '0;
      timeout_err    <= 1'b0;
    end else begin
      tx_elecidle <= 1'b1;
      done        <= 1'b0;
      if (abort) begin
        state       <= IDLE;
        busy        <= 1'b0;
        tx_detectrx <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            tx_detectrx <= 1'b0;
            if (start) begin
              state      <= SETTLE;
              busy       <= 1'b1;
              settle_cnt <= '0;
              retry_cnt  <= '0;
              seen       <= '0;
              result     <= '0;
            end
          end
          SETTLE: begin
            if (settle_cnt == S_LAST) begin
              state       <= DETECT;
              tx_detectrx <= 1'b1;
              timeout_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          DETECT: begin
            seen   <= seen_n;
            result <= result_n;
            if (&seen_n) begin
              state          <= IDLE;
              busy           <= 1'b0;
              tx_detectrx    <= 1'b0;
              done           <= 1'b1;
              detected_lanes <= result_n;
              timeout_err    <= 1'b0;
            end else if (timeout_cnt == T_LAST) begin
              tx_detectrx <= 1'b0;
              if (retry_cnt < R_MAX) begin
                state      <= SETTLE;
                retry_cnt  <= retry_cnt + 1'b1;
                settle_cnt <= '0;
                seen       <= '0;
                result     <= '0;
              end else begin
                state          <= IDLE;
                busy           <= 1'b0;
                done           <= 1'b1;
                detected_lanes <= result_n;
                timeout_err    <= 1'b1;
              end
            end else begin
              timeout_cnt <= timeout_cnt + 1'b1;
            end
          end
          default: begin
            state       <= IDLE;
            busy        <= 1'b0;
            tx_detectrx <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_rxdetect_seq.sv
// Directed bench for pipe_rxdetect_seq with scoreboards on done results
// and TxDetectRx pulse widths.
module tb_pipe_rxdetect_seq;

  localparam int NL = 4;
  localparam int SC = 4;
  localparam int TC = 16;
  localparam int MR = 1;

  logic          pclk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [NL-1:0] phy_status = '0;
  logic [3*NL-1:0] rx_status = '0;
  logic          tx_detectrx;
  logic          tx_elecidle;
  logic          busy;
  logic          done;
  logic [NL-1:0] detected_lanes;
  logic          timeout_err;

  typedef struct packed {
    logic [NL-1:0] det;
    logic          terr;
  } res_t;

  res_t exp_done[$];
  int   exp_tx[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   tx_cnt = 0;
  int   n;

  pipe_rxdetect_seq #(
    .NUM_LANES(NL),
    .SETTLE_CYCLES(SC),
    .TIMEOUT_CYCLES(TC),
    .MAX_RETRIES(MR)
  ) dut (
    .pclk(pclk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .phy_status(phy_status),
    .rx_status(rx_status),
    .tx_detectrx(tx_detectrx),
    .tx_elecidle(tx_elecidle),
    .busy(busy),
    .done(done),
    .detected_lanes(detected_lanes),
    .timeout_err(timeout_err)
  );

  always #5 pclk = ~pclk;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3*NL-1:0] pack(logic [2:0] l0, logic [2:0] l1,
                                           logic [2:0] l2, logic [2:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic step(int k);
    repeat (k) @(posedge pclk);
    #1;
  endtask

  task automatic wait_tx(logic lvl, output int cnt);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge pclk);
      #1;
      cnt++;
      if (tx_detectrx == lvl) return;
    end
    check("wait_tx_bound", 0, 1);
  endtask

  task automatic do_start();
    int c;
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    wait_tx(1'b1, c);
    check("start_to_tx", c, SC);
  endtask

  // Pulse-width scoreboard
  always @(negedge pclk) begin
    if (reset) begin
      tx_cnt = 0;
    end else if (tx_detectrx) begin
      tx_cnt++;
    end else if (tx_cnt != 0) begin
      if (exp_tx.size() == 0) check("tx_unexpected_pulse", tx_cnt, 0);
      else check("tx_width", tx_cnt, exp_tx.pop_front());
      tx_cnt = 0;
    end
  end

  // Completion scoreboard
  always @(negedge pclk) begin
    res_t e;
    if (!reset && done) begin
      if (exp_done.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        e = exp_done.pop_front();
        check("detected_lanes", int'(detected_lanes), int'(e.det));
        check("timeout_err", int'(timeout_err), int'(e.terr));
      end
    end
  end

  initial begin
    step(3);
    check("rst_tx", int'(tx_detectrx), 0);
    check("rst_elecidle", int'(tx_elecidle), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_det", int'(detected_lanes), 0);
    check("rst_terr", int'(timeout_err), 0);
    reset = 1'b0;
    step(2);

    // All lanes present, 3 cycles into detect
    exp_tx.push_back(3);
    exp_done.push_back('{det: 4'b1111, terr: 1'b0});
    do_start();
    step(2);
    phy_status = 4'b1111;
    rx_status = pack(3'b011, 3'b011, 3'b011, 3'b011);
    step(1);
    phy_status = '0;
    rx_status = '0;
    check("elecidle_hold", int'(tx_elecidle), 1);
    step(3);

    // Asynchronous reset mid-detect
    do_start();
    step(2);
    #2 reset = 1'b1;
    #1;
    check("async_rst_tx", int'(tx_detectrx), 0);
    check("async_rst_elecidle", int'(tx_elecidle), 1);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_det", int'(detected_lanes), 0);
    step(2);
    reset = 1'b0;
    step(2);

    // Staggered mixed results with a repeated lane 1
    exp_tx.push_back(4);
    exp_done.push_back('{det: 4'b0101, terr: 1'b0});
    do_start();
    phy_status = 4'b0001;
    rx_status = pack(3'b011, 3'b000, 3'b000, 3'b000);
    step(1);
    phy_status = 4'b0010;
    rx_status = pack(3'b000, 3'b000, 3'b000, 3'b000);
    step(1);
    phy_status = 4'b0110;
    rx_status = pack(3'b000, 3'b011, 3'b011, 3'b000);
    step(1);
    phy_status = 4'b1000;
    rx_status = pack(3'b000, 3'b000, 3'b000, 3'b000);
    step(1);
    phy_status = '0;
    step(4);

    // Lane 3 silent: timeout, retry, final timeout
    exp_tx.push_back(TC);
    exp_tx.push_back(TC);
    exp_done.push_back('{det: 4'b0111, terr: 1'b1});
    do_start();
    phy_status = 4'b0111;
    rx_status = pack(3'b000, 3'b000, 3'b000, 3'b000);
    step(1);
    phy_status = '0;
    wait_tx(1'b0, n);
    check("retry_busy", int'(busy), 1);
    wait_tx(1'b1, n);
    check("retry_gap", n, SC);
    phy_status = 4'b0111;
    rx_status = pack(3'b011, 3'b011, 3'b011, 3'b000);
    step(1);
    phy_status = '0;
    rx_status = '0;
    wait_tx(1'b0, n);
    check("final_busy", int'(busy), 0);
    step(3);

    // Abort 5 cycles into detect
    exp_tx.push_back(5);
    do_start();
    step(4);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort_tx", int'(tx_detectrx), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_det", int'(detected_lanes), 4'b0111);
    check("abort_terr", int'(timeout_err), 1);
    step(8);

    // Ignored inputs, then completion exactly on the timeout edge
    phy_status = 4'b1111;
    rx_status = pack(3'b011, 3'b011, 3'b011, 3'b011);
    step(1);
    phy_status = '0;
    check("idle_phy_busy", int'(busy), 0);
    check("idle_phy_det", int'(detected_lanes), 4'b0111);
    exp_tx.push_back(TC);
    exp_done.push_back('{det: 4'b1111, terr: 1'b0});
    start = 1'b1;
    step(1);
    start = 1'b1;
    phy_status = 4'b1111;
    step(1);
    start = 1'b0;
    phy_status = '0;
    wait_tx(1'b1, n);
    check("restart_ignored", n, SC - 1);
    step(TC - 1);
    phy_status = 4'b1111;
    step(1);
    phy_status = '0;
    rx_status = '0;
    check("edge_done_busy", int'(busy), 0);
    step(40);

    check("pending_done", exp_done.size(), 0);
    check("pending_tx", exp_tx.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
